bus_mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (program + data) between three requesters: debug/loader port, CPU data bus, CPU instruction bus.
- The debug port has absolute priority, so memory can be preloaded or patched while the CPU is held in reset.
- Data and instruction buses are round-robin arbitrated between themselves.
- Sits between the CPU core and the on-chip RAM, alongside the debug memory-op path.

---
 rtl/bus_mem_arbiter.sv | 75 +++++++
 tb/tb_bus_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_arbiter.sv
// bus_mem_arbiter: shares one single-port sync RAM between debug (absolute priority) and round-robin CPU data/instruction ports.
module bus_mem_arbiter #(
  parameter int          ADR_W    = 13,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_adr,
  input  logic [31:0]      dbg_wdata,
  input  logic [3:0]       dbg_wmask,
  output logic             dbg_ack,
  output logic             dbg_rvalid,
  output logic [31:0]      dbg_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_adr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_wmask,
  output logic             d_ack,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  input  logic             i_req,
  input  logic [31:0]      i_adr,
  output logic             i_ack,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic [ADR_W-1:0] ram_adr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_wren,
  input  logic [31:0]      ram_rdata
);
  typedef enum logic [1:0] {OWN_DBG, OWN_D, OWN_I} owner_t;
  logic        last_cpu, p_valid, p_win;
  owner_t      p_own;
  logic        g_dbg, g_d, g_i, sel_we, win;
  logic [31:0] sel_adr, off, rd;
  // last_cpu=0 means data was granted last, so instr wins the next tie
  always_comb begin
    g_dbg   = !reset && dbg_req;
    g_d     = !reset && !dbg_req && d_req && (!i_req || last_cpu);
    g_i     = !reset && !dbg_req && i_req && (!d_req || !last_cpu);
    sel_adr = g_dbg ? dbg_adr : g_d ? d_adr : i_adr;
    sel_we  = g_dbg ? dbg_we : (g_d && d_we);
    off     = sel_adr - RAM_BASE;
    win     = (off >> (ADR_W + 2)) == 32'd0;
    rd      = p_win ? ram_rdata : 32'h0;
  end
  assign dbg_ack    = g_dbg;
  assign d_ack      = g_d;
  assign i_ack      = g_i;
  assign ram_adr    = off[ADR_W+1:2];
  assign ram_wdata  = g_dbg ? dbg_wdata : d_wdata;
  assign ram_wren   = (sel_we && win) ? (g_dbg ? dbg_wmask : d_wmask) : 4'h0;
  assign dbg_rvalid = !reset && p_valid && p_own == OWN_DBG;
  assign d_rvalid   = !reset && p_valid && p_own == OWN_D;
  assign i_rvalid   = !reset && p_valid && p_own == OWN_I;
  assign dbg_rdata  = rd;
  assign d_rdata    = rd;
  assign i_rdata    = rd;
  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu <= 1'b0;
      p_valid  <= 1'b0;
      p_own    <= OWN_DBG;
      p_win    <= 1'b0;
    end else begin
      if (g_d || g_i) last_cpu <= g_i;
      p_valid <= (g_dbg || g_d || g_i) && !sel_we;
      p_own   <= g_dbg ? OWN_DBG : g_d ? OWN_D : OWN_I;
      p_win   <= win;
    end
  end
endmodule

// File: tb/tb_bus_mem_arbiter.sv
// tb_bus_mem_arbiter: scoreboard bench with a RAM model and a shadow memory predicting read data.
module tb_bus_mem_arbiter;
  logic        clk = 0, reset = 1;
  logic        dbg_req = 0, dbg_we = 0, dbg_ack, dbg_rvalid;
  logic [31:0] dbg_adr = 0, dbg_wdata = 0, dbg_rdata;
  logic [3:0]  dbg_wmask = 0;
  logic        d_req = 0, d_we = 0, d_ack, d_rvalid;
  logic [31:0] d_adr = 0, d_wdata = 0, d_rdata;
  logic [3:0]  d_wmask = 0;
  logic        i_req = 0, i_ack, i_rvalid;
  logic [31:0] i_adr = 0, i_rdata;
  logic [3:0]  ram_adr, ram_wren;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [16];
  logic [31:0] sh [16];
  int errs = 0, checks = 0, cyc = 0, d_rv_cnt = 0;
  logic [31:0] last_d = 0;
  logic lc = 0;
  typedef struct {int cy; int port; logic [31:0] data;} exp_t;
  exp_t sb[$];
  logic [7:0] glog[$];

  bus_mem_arbiter #(.ADR_W(4), .RAM_BASE(32'h0)) dut (
    .clk(clk), .reset(reset),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask),
    .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (ram_wren[b]) mem[ram_adr][8*b+:8] <= ram_wdata[8*b+:8];
    ram_rdata <= mem[ram_adr];
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] erv;
    logic [31:0] erd, a, wd;
    logic eg, ed, ei, we, w;
    logic [3:0] msk;
    int wp;
    exp_t x;
    erv = 0;
    erd = 0;
    if (sb.size() > 0 && sb[0].cy == cyc) begin
      x = sb.pop_front();
      if (!reset) begin
        erv[x.port] = 1'b1;
        erd = x.data;
      end
    end
    chk("dbg_rvalid", dbg_rvalid, erv[0]);
    chk("d_rvalid", d_rvalid, erv[1]);
    chk("i_rvalid", i_rvalid, erv[2]);
    if (erv != 0) chk("rdata", erv[0] ? dbg_rdata : erv[1] ? d_rdata : i_rdata, erd);
    if (d_rvalid) begin
      last_d = d_rdata;
      d_rv_cnt++;
    end
    eg = !reset && dbg_req;
    ed = !reset && !dbg_req && d_req && (!i_req || lc);
    ei = !reset && !dbg_req && i_req && (!d_req || !lc);
    chk("dbg_ack", dbg_ack, eg);
    chk("d_ack", d_ack, ed);
    chk("i_ack", i_ack, ei);
    if (reset) lc = 0;
    else if (ed || ei) lc = ei;
    wp = eg ? 0 : ed ? 1 : ei ? 2 : -1;
    if (wp >= 0) begin
      glog.push_back(eg ? 8'h67 : ed ? 8'h64 : 8'h69);
      a   = eg ? dbg_adr : ed ? d_adr : i_adr;
      we  = eg ? dbg_we : ed ? d_we : 1'b0;
      msk = eg ? dbg_wmask : d_wmask;
      wd  = eg ? dbg_wdata : d_wdata;
      w   = a < 32'h40;
      chk("ram_wren", ram_wren, (we && w) ? msk : 4'h0);
      if (w) chk("ram_adr", ram_adr, a[5:2]);
      if (we && w) begin
        for (int b = 0; b < 4; b++) if (msk[b]) sh[a[5:2]][8*b+:8] = wd[8*b+:8];
      end else if (!we) sb.push_back('{cyc + 1, wp, w ? sh[a[5:2]] : 32'h0});
    end else chk("ram_wren_idle", ram_wren, 4'h0);
  end

  task automatic wait_ack(input int p);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = p == 0 ? dbg_ack : p == 1 ? d_ack : i_ack;
    end
    if (!got) chk("ack_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_op(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    dbg_req = 1; dbg_we = w; dbg_adr = a; dbg_wdata = wd; dbg_wmask = m;
    wait_ack(0);
    dbg_req = 0;
  endtask

  task automatic d_op(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    d_req = 1; d_we = w; d_adr = a; d_wdata = wd; d_wmask = m;
    wait_ack(1);
    d_req = 0;
  endtask

  task automatic i_op(input logic [31:0] a);
    i_req = 1; i_adr = a;
    wait_ack(2);
    i_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] order;
    int c0;
    order = "ggggidid";
    idle(2);
    reset = 0;
    for (int k = 0; k < 16; k++) dbg_op(1, 32'(4 * k), 32'hC0DE0000 | 32'(k), 4'hF);
    dbg_op(1, 32'h0, 32'h00000137, 4'hF);
    dbg_op(0, 32'h0, 32'h0, 4'h0);
    idle(1);
    dbg_op(1, 32'hC, 32'h00000032, 4'h1);
    d_op(1, 32'hD, 32'h00003100, 4'h2);
    d_op(0, 32'hC, 32'h0, 4'h0);
    idle(1);
    chk("byte_mask", last_d, 32'hC0DE3132);
    reset = 1;
    idle(1);
    reset = 0;
    glog.delete();
    fork
      begin repeat (4) dbg_op(0, 32'h10, 32'h0, 4'h0); end
      begin d_op(0, 32'h14, 32'h0, 4'h0); d_op(0, 32'h18, 32'h0, 4'h0); end
      begin i_op(32'h1C); i_op(32'h20); end
    join
    idle(2);
    chk("grant_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("grant_order", glog[k], order[63-8*k -: 8]);
    d_op(1, 32'h40, 32'hDEADBEEF, 4'hF);
    d_op(0, 32'h40, 32'h0, 4'h0);
    idle(1);
    chk("oow_rdata", last_d, 32'h0);
    i_op(32'h8);
    reset = 1;
    @(negedge clk);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    @(posedge clk);
    #1;
    glog.delete();
    fork
      begin @(posedge clk); #1; reset = 0; end
      d_op(0, 32'h4, 32'h0, 4'h0);
      i_op(32'hC);
    join
    idle(2);
    chk("rst_grant_count", glog.size(), 2);
    if (glog.size() > 0) chk("rst_first_grant", glog[0], 8'h69);
    c0 = d_rv_cnt;
    d_op(0, 32'h0, 32'h0, 4'h0);
    d_op(0, 32'h4, 32'h0, 4'h0);
    d_op(0, 32'h8, 32'h0, 4'h0);
    idle(1);
    chk("b2b_last", last_d, 32'hC0DE0002);
    idle(1);
    chk("b2b_count", d_rv_cnt - c0, 3);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
